// File: rtl/pcie_vc_sched.sv
// pcie_vc_sched: two-VC FIFO buffering with pause-aware arbitration onto one tagged link word.
// Define PCIE_SCHED_STRICT_PRIO_EN for VC0 strict priority; otherwise round-robin.
module pcie_vc_sched #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              in_valid_vc0,
    input  logic [DATA_W-1:0] in_data_vc0,
    output logic              in_ready_vc0,
    input  logic              in_valid_vc1,
    input  logic [DATA_W-1:0] in_data_vc1,
    output logic              in_ready_vc1,
    input  logic              pause_VC0P0,
    input  logic              pause_VC1P1,
    output logic              valid_p0,
    output logic              valid_p1,
    output logic [DATA_W:0]   data_p0,
    output logic [DATA_W:0]   data_p1,
    output logic              ovf_error,
    output logic              idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]        in_valid, ready, pause, elig, gnt;
    logic [DATA_W-1:0] in_data [2];
    logic [DATA_W-1:0] head    [2];
    logic [CW-1:0]     cnt     [2];
    logic              valid_q, ovf_q;
    logic [DATA_W:0]   data_q, data_d;

    assign in_valid   = {in_valid_vc1, in_valid_vc0};
    assign pause      = {pause_VC1P1, pause_VC0P0};
    assign in_data[0] = in_data_vc0;
    assign in_data[1] = in_data_vc1;

    for (genvar v = 0; v < 2; v++) begin : g_fifo
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wp_q, rp_q;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              push;
        assign ready[v] = cnt_q != CW'(DEPTH);
        assign push     = in_valid[v] && ready[v];
        assign elig[v]  = (cnt_q != '0) && !pause[v];
        assign head[v]  = mem_q[rp_q];
        assign cnt[v]   = cnt_q;
        assign cnt_d    = cnt_q + CW'(push) - CW'(gnt[v]);
        always_ff @(posedge clk)
            if (push) mem_q[wp_q] <= in_data[v];
        always_ff @(posedge clk or negedge reset_L)
            if (!reset_L) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                wp_q  <= wp_q + AW'(push);
                rp_q  <= rp_q + AW'(gnt[v]);
                cnt_q <= cnt_d;
            end
    end

`ifdef PCIE_SCHED_STRICT_PRIO_EN
    assign gnt = {elig[1] && !elig[0], elig[0]};
`else
    // last_q = 1 means VC1 was granted last, so VC0 wins the next tie
    logic last_q;
    assign gnt[0] = elig[0] && (!elig[1] || last_q);
    assign gnt[1] = elig[1] && !gnt[0];
`endif

    assign data_d = gnt[1] ? {1'b1, head[1]} : gnt[0] ? {1'b0, head[0]} : '0;

    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
`ifndef PCIE_SCHED_STRICT_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            valid_q <= |gnt;
            data_q  <= data_d;
            ovf_q   <= ovf_q | |(in_valid & ~ready);
`ifndef PCIE_SCHED_STRICT_PRIO_EN
            if (|gnt) last_q <= gnt[1];
`endif
        end

    assign in_ready_vc0 = ready[0];
    assign in_ready_vc1 = ready[1];
    assign valid_p0     = valid_q;
    assign valid_p1     = valid_q;
    assign data_p0      = data_q;
    assign data_p1      = data_q;
    assign ovf_error    = ovf_q;
    assign idle         = (cnt[0] == '0) && (cnt[1] == '0) && !valid_q;
endmodule

// File: doc/pcie_vc_sched.md
# pcie_vc_sched

Upstream traffic scheduler for the PCIE transaction stage. Accepts two independent 5-bit word streams, one per virtual channel (VC0, VC1), and buffers each in its own small FIFO. It merges them onto one tagged 6-bit link word per cycle, with bit 5 = VC id. Pause flags fed back from the transaction stage's per-VC FIFOs throttle each channel, so no word is issued toward a VC that has asked to pause.

## Interface
Parameters:
- DEPTH, 4, entries per VC FIFO; power of 2, ≥2
- DATA_W, 5, payload width; link word is DATA_W+1 bits

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- in_valid_vc0  in  1  VC0 write request
- in_data_vc0  in  DATA_W  VC0 payload
- in_ready_vc0  out  1  VC0 FIFO can accept (not full)
- in_valid_vc1  in  1  VC1 write request
- in_data_vc1  in  DATA_W  VC1 payload
- in_ready_vc1  out  1  VC1 FIFO can accept
- pause_VC0P0  in  1  downstream VC0 pause request
- pause_VC1P1  in  1  downstream VC1 pause request
- valid_p0, valid_p1  out  1 each  link word valid (identical copies)
- data_p0, data_p1  out  DATA_W+1 each  link word {vc_id, payload} (identical copies)
- ovf_error  out  1  sticky protocol error
- idle  out  1  both FIFOs empty and no word on link

## Operation
- Per-VC FIFO: circular buffer with rd/wr pointers (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits).
- in_ready_vcX = (count_X != DEPTH), derived from the registered count only.
- Push when in_valid_vcX && in_ready_vcX.
- in_valid_vcX while in_ready_vcX is low: the word is dropped and ovf_error is set. ovf_error is sticky and clears only on reset.
- Eligibility: elig_X = (count_X != 0) && !pause_X. Pause is sampled combinationally in the grant cycle.
- Arbitration, one grant per cycle:
  - If only one VC is eligible, grant it.
  - If both are eligible, round-robin: grant the VC not in last_grant. last_grant updates only when a grant is issued.
- On grant: pop that FIFO. Register the link word: data = {vc_id, head_entry}, valid = 1.
- With no grant: valid_p* = 0 and data_p* = 0.
- data_p1/valid_p1 always mirror data_p0/valid_p0. The downstream stage filters on bit 5.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle, because eligibility uses the registered count.
  - A pop from a full FIFO does not raise in_ready in that same cycle.
- idle = (count_0 == 0) && (count_1 == 0) && !valid_p0, registered view.

## Timing
- Reset values: valid_p0/p1 = 0, data_p0/p1 = 0, ovf_error = 0, in_ready_vc0/vc1 = 1, idle = 1, counts and pointers = 0, last_grant = VC1 (so VC0 wins the first tie).
- Reset takes effect immediately on reset_L falling, including mid-transfer. All buffered words are discarded.
- Latency: a word pushed at edge N is earliest on the link after edge N+1 (one-cycle cut-through minimum).
- Throughput: one link word per cycle total. With both VCs busy and unpaused, the link alternates VC0, VC1, VC0, …
- A pause asserted in cycle C blocks any grant to that VC at edge C. A word already on the link is not recalled.

## Configuration
- PCIE_SCHED_STRICT_PRIO_EN defined: VC0 has strict priority. When both VCs are eligible, VC0 always wins and last_grant is unused. VC1 issues only when VC0 is empty or paused.
- Not defined: round-robin arbitration as described above.

## Test plan
- Reset then single write: push VC0 word 5'h0A at edge 1 → after edge 2, valid_p0 = valid_p1 = 1 and data = 6'h0A; then idle = 1.
- Round-robin: preload VC0 {1,2,3} and VC1 {4,5,6}, no pause → link sequence 0x01, 0x24, 0x02, 0x25, 0x03, 0x26. With PCIE_SCHED_STRICT_PRIO_EN: 0x01, 0x02, 0x03, 0x24, 0x25, 0x26.
- Pause: hold pause_VC0P0 = 1 with both FIFOs loaded → only bit-5=1 words appear. Release pause → VC0 words resume the next cycle.
- Full/overflow: DEPTH = 4, pause VC1 and push 4 words → in_ready_vc1 = 0. A 5th push sets ovf_error = 1 and drops the word. Release pause → exactly 4 words come out, in order.
- Wrap-around: stream 10 VC0 words at one per cycle, unpaused → output in order, no gaps after the first, in_ready_vc0 stays 1, ovf_error stays 0.
- Mid-operation reset: pull reset_L low while both FIFOs are non-empty → valid_p* drops immediately. After release, idle = 1 and no stale words appear.
